// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : mem_arbiter
// Description : Round-robin arbiter/sequencer sharing one cached-memory port
//               between instruction fetch and load/store, with watchdog abort.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int ramWidth     = 8,
    parameter int addrSize     = 8,
    parameter int timeoutWidth = 8
) (
    input  logic                clk,
    input  logic                clrN,

    input  logic                fetchReq,
    input  logic [addrSize-1:0] fetchAddr,
    output logic                fetchAck,
    output logic [ramWidth-1:0] fetchData,

    input  logic                dataReq,
    input  logic                dataWe,
    input  logic                dataIndirect,
    input  logic [addrSize-1:0] dataAddr,
    input  logic [ramWidth-1:0] dataWData,
    output logic                dataAck,
    output logic [ramWidth-1:0] dataRData,

    output logic [1:0]          memCntrl,
    output logic [addrSize-1:0] memAddr,
    output logic [ramWidth-1:0] memDataIn,
    output logic                memIsIndirect,
    input  logic [ramWidth-1:0] memDataOut,
    input  logic                memDataReady,

    output logic                busy,
    output logic                timeoutErr
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] c_CMD_IDLE  = 2'b00;
    localparam logic [1:0] c_CMD_READ  = 2'b01;
    localparam logic [1:0] c_CMD_WRITE = 2'b10;

    // The current WAIT cycle is included in the count, so the abort fires at
    // the end of WAIT cycle number 2^timeoutWidth-1.
    localparam logic [timeoutWidth-1:0] c_WD_ONES = '1;
    localparam logic [timeoutWidth-1:0] c_WD_LAST = c_WD_ONES - timeoutWidth'(1);

    state_t                  r_state;
    state_t                  w_nextState;
    logic                    r_lastGrantData;
    logic [timeoutWidth-1:0] r_wdCount;

    logic w_anyReq;
    logic w_pickData;
    logic w_grant;
    logic w_done;
    logic w_abort;

    assign w_anyReq   = fetchReq | dataReq;
    // Data wins only when fetch is absent or fetch was the last one served.
    assign w_pickData = dataReq & (~fetchReq | ~r_lastGrantData);
    assign w_grant    = (r_state == S_IDLE) & w_anyReq;
    assign w_done     = (r_state == S_WAIT) & memDataReady;
    assign w_abort    = (r_state == S_WAIT) & ~memDataReady & (r_wdCount == c_WD_LAST);

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (w_anyReq) w_nextState = S_WAIT;
            S_WAIT:    if (w_done || w_abort) w_nextState = S_RELEASE;
            S_RELEASE: w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            r_lastGrantData <= 1'b1;
            r_wdCount       <= '0;
            memCntrl        <= c_CMD_IDLE;
            memAddr         <= '0;
            memDataIn       <= '0;
            memIsIndirect   <= 1'b0;
            fetchAck        <= 1'b0;
            dataAck         <= 1'b0;
            fetchData       <= '0;
            dataRData       <= '0;
            busy            <= 1'b0;
            timeoutErr      <= 1'b0;
        end else begin
            fetchAck <= 1'b0;
            dataAck  <= 1'b0;
            busy     <= (w_nextState != S_IDLE);

            if (w_grant) begin
                r_lastGrantData <= w_pickData;
                r_wdCount       <= '0;
                memAddr         <= w_pickData ? dataAddr : fetchAddr;
                memDataIn       <= w_pickData ? dataWData : '0;
                memIsIndirect   <= w_pickData & dataIndirect;
                memCntrl        <= (w_pickData && dataWe) ? c_CMD_WRITE : c_CMD_READ;
            end

            if (r_state == S_WAIT) begin
                r_wdCount <= r_wdCount + timeoutWidth'(1);
                if (w_done || w_abort) begin
                    memCntrl <= c_CMD_IDLE;
                    fetchAck <= ~r_lastGrantData;
                    dataAck  <= r_lastGrantData;
                end
                if (w_abort) begin
                    timeoutErr <= 1'b1;
                end
                // Only completed reads refresh the granted port's read data.
                if (w_done && (memCntrl == c_CMD_READ)) begin
                    if (r_lastGrantData) begin
                        dataRData <= memDataOut;
                    end else begin
                        fetchData <= memDataOut;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter against a transaction-level
//               model of arbitration, completion and watchdog behaviour.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

    localparam int c_TW = 3;

    logic       clk = 1'b0;
    logic       clrN;
    logic       fetchReq;
    logic [7:0] fetchAddr;
    logic       fetchAck;
    logic [7:0] fetchData;
    logic       dataReq;
    logic       dataWe;
    logic       dataIndirect;
    logic [7:0] dataAddr;
    logic [7:0] dataWData;
    logic       dataAck;
    logic [7:0] dataRData;
    logic [1:0] memCntrl;
    logic [7:0] memAddr;
    logic [7:0] memDataIn;
    logic       memIsIndirect;
    logic [7:0] memDataOut;
    logic       memDataReady;
    logic       busy;
    logic       timeoutErr;

    int nChecks = 0;
    int nFail   = 0;

    // Reference model state
    bit         mLastData;
    bit         mErr;
    logic [7:0] mFetchData;
    logic [7:0] mDataRData;

    mem_arbiter #(.ramWidth(8), .addrSize(8), .timeoutWidth(c_TW)) dut (
        .clk(clk), .clrN(clrN),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchAck(fetchAck), .fetchData(fetchData),
        .dataReq(dataReq), .dataWe(dataWe), .dataIndirect(dataIndirect), .dataAddr(dataAddr),
        .dataWData(dataWData), .dataAck(dataAck), .dataRData(dataRData),
        .memCntrl(memCntrl), .memAddr(memAddr), .memDataIn(memDataIn),
        .memIsIndirect(memIsIndirect), .memDataOut(memDataOut), .memDataReady(memDataReady),
        .busy(busy), .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fetchAck || dataAck || memCntrl == 2'b11) begin
            nChecks++;
            if ((fetchAck && dataAck) || memCntrl == 2'b11) begin
                nFail++;
                $display("FAIL ack_exclusive: fetchAck=%0b dataAck=%0b memCntrl=%b, required one ack and cntrl!=11",
                         fetchAck, dataAck, memCntrl);
            end
        end
    end

    function automatic bit predictData(bit f, bit d, bit lastData);
        return d && (!f || !lastData);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mLastData  = 1'b1;
        mErr       = 1'b0;
        mFetchData = 8'h00;
        mDataRData = 8'h00;
    endtask

    task automatic apply_reset();
        clrN = 1'b0; fetchReq = 1'b0; dataReq = 1'b0; memDataReady = 1'b0;
        tick(); tick();
        clrN = 1'b1;
        model_reset();
    endtask

    task automatic wait_issue(output bit ok, output int cyc);
        ok = 1'b0; cyc = 0;
        while (!ok && cyc < 10) begin
            tick();
            cyc++;
            if (memCntrl != 2'b00) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        clrN = 1'b0; fetchReq = 1'b0; dataReq = 1'b0; dataWe = 1'b0; dataIndirect = 1'b0;
        fetchAddr = 8'h00; dataAddr = 8'h00; dataWData = 8'h00;
        memDataOut = 8'h00; memDataReady = 1'b0;
        model_reset();
        tick(); tick(); tick();
        nChecks++;
        if ({memCntrl, memAddr, memDataIn, memIsIndirect, fetchAck, dataAck, fetchData, dataRData, timeoutErr} !== '0) begin
            nFail++;
            $display("FAIL reset_outputs: cntrl=%b addr=%h din=%h ind=%b fa=%b da=%b fd=%h dd=%h err=%b, required all zero",
                     memCntrl, memAddr, memDataIn, memIsIndirect, fetchAck, dataAck, fetchData, dataRData, timeoutErr);
        end
        nChecks++;
        if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b required 0", busy); end
        clrN = 1'b1;
        tick(); tick();
        nChecks++;
        if (memCntrl !== 2'b00 || busy !== 1'b0) begin
            nFail++; $display("FAIL idle_no_req: cntrl=%b busy=%b, required 00/0", memCntrl, busy);
        end
    endtask

    task automatic test_single_fetch();
        bit ok; int cyc; bit stable;
        fetchAddr = 8'h12; fetchReq = 1'b1;
        wait_issue(ok, cyc);
        nChecks++;
        if (!ok || cyc != 1) begin nFail++; $display("FAIL fetch_latency: ok=%0b cycles=%0d required 1", ok, cyc); end
        nChecks++;
        if ({memCntrl, memAddr, memIsIndirect, busy} !== {2'b01, 8'h12, 1'b0, 1'b1}) begin
            nFail++; $display("FAIL fetch_cmd: cntrl=%b addr=%h ind=%b busy=%b, required 01/12/0/1",
                              memCntrl, memAddr, memIsIndirect, busy);
        end
        stable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (memCntrl !== 2'b01 || memAddr !== 8'h12 || fetchAck !== 1'b0) stable = 1'b0;
        end
        nChecks++;
        if (!stable) begin nFail++; $display("FAIL fetch_hold: cmd changed before ready, got 0 required 1"); end
        memDataOut = 8'hA5; memDataReady = 1'b1;
        tick();
        memDataReady = 1'b0; fetchReq = 1'b0;
        nChecks++;
        if ({fetchAck, dataAck} !== 2'b10) begin nFail++; $display("FAIL fetch_ack: got %b required 10", {fetchAck, dataAck}); end
        nChecks++;
        if (fetchData !== 8'hA5) begin nFail++; $display("FAIL fetch_data: got %h required a5", fetchData); end
        nChecks++;
        if (memCntrl !== 2'b00) begin nFail++; $display("FAIL fetch_release: cntrl=%b required 00", memCntrl); end
        mFetchData = 8'hA5; mLastData = 1'b0;
        // Ready strobes while not waiting must be ignored.
        memDataOut = 8'h5F; memDataReady = 1'b1;
        tick();
        nChecks++;
        if (fetchAck !== 1'b0 || memCntrl !== 2'b00 || busy !== 1'b0) begin
            nFail++; $display("FAIL fetch_pulse: fa=%b cntrl=%b busy=%b required 0/00/0", fetchAck, memCntrl, busy);
        end
        tick();
        memDataReady = 1'b0;
        nChecks++;
        if ({fetchAck, dataAck} !== 2'b00 || fetchData !== mFetchData) begin
            nFail++; $display("FAIL stray_ready: acks=%b fd=%h required 00/%h", {fetchAck, dataAck}, fetchData, mFetchData);
        end
    endtask

    task automatic test_round_robin();
        bit ok; int cyc; bit expD; int nF; int nD; logic [7:0] rd;
        apply_reset();
        fetchAddr = 8'h20; dataAddr = 8'h40; dataWe = 1'b0; dataIndirect = 1'b0;
        fetchReq = 1'b1; dataReq = 1'b1;
        nF = 0; nD = 0;
        for (int k = 0; k < 4; k++) begin
            wait_issue(ok, cyc);
            expD = predictData(1'b1, 1'b1, mLastData);
            nChecks++;
            if (!ok || cyc != ((k == 0) ? 1 : 2)) begin
                nFail++; $display("FAIL rr_spacing[%0d]: ok=%0b cycles=%0d required %0d", k, ok, cyc, (k == 0) ? 1 : 2);
            end
            nChecks++;
            if (memAddr !== (expD ? 8'h40 : 8'h20) || memCntrl !== 2'b01) begin
                nFail++; $display("FAIL rr_winner[%0d]: addr=%h cntrl=%b required %h/01", k, memAddr, memCntrl, expD ? 8'h40 : 8'h20);
            end
            rd = 8'($urandom);
            memDataOut = rd; memDataReady = 1'b1;
            tick();
            memDataReady = 1'b0;
            nChecks++;
            if (fetchAck !== !expD || dataAck !== expD) begin
                nFail++; $display("FAIL rr_ack[%0d]: fa=%b da=%b required %b/%b", k, fetchAck, dataAck, !expD, expD);
            end
            if (fetchAck) nF++;
            if (dataAck) nD++;
            mLastData = expD;
            if (expD) mDataRData = rd; else mFetchData = rd;
            nChecks++;
            if (fetchData !== mFetchData || dataRData !== mDataRData) begin
                nFail++; $display("FAIL rr_data[%0d]: fd=%h dd=%h required %h/%h", k, fetchData, dataRData, mFetchData, mDataRData);
            end
        end
        fetchReq = 1'b0; dataReq = 1'b0;
        nChecks++;
        if (nF != 2 || nD != 2) begin nFail++; $display("FAIL rr_counts: fetch=%0d data=%0d required 2/2", nF, nD); end
        tick(); tick();
    endtask

    task automatic test_store();
        bit ok; int cyc; bit stable;
        dataWe = 1'b1; dataAddr = 8'h07; dataWData = 8'h3C; dataIndirect = 1'b1; dataReq = 1'b1;
        wait_issue(ok, cyc);
        nChecks++;
        if (!ok || {memCntrl, memAddr, memDataIn, memIsIndirect} !== {2'b10, 8'h07, 8'h3C, 1'b1}) begin
            nFail++; $display("FAIL store_cmd: ok=%0b cntrl=%b addr=%h din=%h ind=%b required 10/07/3c/1",
                              ok, memCntrl, memAddr, memDataIn, memIsIndirect);
        end
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({memCntrl, memAddr, memDataIn, memIsIndirect} !== {2'b10, 8'h07, 8'h3C, 1'b1}) stable = 1'b0;
        end
        nChecks++;
        if (!stable) begin nFail++; $display("FAIL store_hold: cmd changed before ready, got 0 required 1"); end
        memDataOut = 8'hEE; memDataReady = 1'b1;
        tick();
        memDataReady = 1'b0; dataReq = 1'b0;
        mLastData = 1'b1;
        nChecks++;
        if ({fetchAck, dataAck} !== 2'b01 || dataRData !== mDataRData) begin
            nFail++; $display("FAIL store_ack: acks=%b dd=%h required 01/%h", {fetchAck, dataAck}, dataRData, mDataRData);
        end
        dataWe = 1'b0; dataIndirect = 1'b0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        bit ok; int cyc; int t; bit got;
        nChecks++;
        if (timeoutErr !== mErr) begin nFail++; $display("FAIL err_before: got %b required %b", timeoutErr, mErr); end
        fetchAddr = 8'h55; fetchReq = 1'b1;
        wait_issue(ok, cyc);
        t = 0; got = 1'b0;
        while (!got && t < 20) begin
            tick(); t++;
            if (fetchAck || dataAck) got = 1'b1;
        end
        nChecks++;
        if (!ok || !got || t != 7 || fetchAck !== 1'b1) begin
            nFail++; $display("FAIL timeout_ack: got=%0b waitCycles=%0d fa=%b required ack after 7", got, t, fetchAck);
        end
        fetchReq = 1'b0; mErr = 1'b1; mLastData = 1'b0;
        nChecks++;
        if (fetchData !== mFetchData || timeoutErr !== 1'b1 || memCntrl !== 2'b00) begin
            nFail++; $display("FAIL timeout_state: fd=%h err=%b cntrl=%b required %h/1/00", fetchData, timeoutErr, memCntrl, mFetchData);
        end
        tick();
        dataWe = 1'b0; dataAddr = 8'h33; dataReq = 1'b1;
        wait_issue(ok, cyc);
        memDataOut = 8'h5A;
        tick();
        memDataReady = 1'b1;
        tick();
        memDataReady = 1'b0; dataReq = 1'b0;
        mDataRData = 8'h5A; mLastData = 1'b1;
        nChecks++;
        if (dataAck !== 1'b1 || dataRData !== 8'h5A || timeoutErr !== 1'b1) begin
            nFail++; $display("FAIL err_sticky: da=%b dd=%h err=%b required 1/5a/1", dataAck, dataRData, timeoutErr);
        end
        tick(); tick();
    endtask

    task automatic test_ready_at_terminal();
        bit ok; int cyc; logic [7:0] rd;
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            fetchAddr = 8'h60 + 8'(r); fetchReq = 1'b1;
            wait_issue(ok, cyc);
            for (int i = 0; i < 6; i++) tick();
            rd = 8'hC0 + 8'(r);
            memDataOut = rd; memDataReady = 1'b1;
            tick();
            memDataReady = 1'b0; fetchReq = 1'b0;
            mFetchData = rd; mLastData = 1'b0;
            nChecks++;
            if (!ok || fetchAck !== 1'b1 || fetchData !== rd || timeoutErr !== 1'b0) begin
                nFail++; $display("FAIL terminal_ready[%0d]: fa=%b fd=%h err=%b required 1/%h/0", r, fetchAck, fetchData, timeoutErr, rd);
            end
            tick(); tick();
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int cyc;
        fetchAddr = 8'h77; fetchReq = 1'b1;
        wait_issue(ok, cyc);
        tick();
        nChecks++;
        if (memCntrl !== 2'b01 || busy !== 1'b1) begin
            nFail++; $display("FAIL midwait_pre: cntrl=%b busy=%b required 01/1", memCntrl, busy);
        end
        #2 clrN = 1'b0;
        #1;
        nChecks++;
        if ({memCntrl, memAddr, memDataIn, memIsIndirect, fetchAck, dataAck, fetchData, dataRData, busy, timeoutErr} !== '0) begin
            nFail++; $display("FAIL async_reset: cntrl=%b addr=%h fd=%h busy=%b, required all zero", memCntrl, memAddr, fetchData, busy);
        end
        memDataReady = 1'b1;
        tick();
        clrN = 1'b1; fetchReq = 1'b0; memDataReady = 1'b0;
        model_reset();
        tick();
        nChecks++;
        if ({fetchAck, dataAck} !== 2'b00 || memCntrl !== 2'b00 || busy !== 1'b0) begin
            nFail++; $display("FAIL dropped_access: acks=%b cntrl=%b busy=%b required 00/00/0", {fetchAck, dataAck}, memCntrl, busy);
        end
    endtask

    task automatic test_random();
        bit ok; int cyc; bit expD; int d; int t; int expT; bit got; bit tout;
        logic [7:0] rd; logic [18:0] expCmd; logic [18:0] gotCmd;
        for (int k = 0; k < 40; k++) begin
            if (!fetchReq && $urandom_range(0, 1) == 1) begin
                fetchReq = 1'b1; fetchAddr = 8'($urandom);
            end
            if (!dataReq && $urandom_range(0, 1) == 1) begin
                dataReq = 1'b1; dataAddr = 8'($urandom); dataWData = 8'($urandom);
                dataWe = 1'($urandom_range(0, 1)); dataIndirect = 1'($urandom_range(0, 1));
            end
            if (!fetchReq && !dataReq) begin
                fetchReq = 1'b1; fetchAddr = 8'($urandom);
            end
            expD = predictData(fetchReq, dataReq, mLastData);
            wait_issue(ok, cyc);
            if (expD) expCmd = {(dataWe ? 2'b10 : 2'b01), dataAddr, (dataWe ? dataWData : memDataIn), dataIndirect};
            else      expCmd = {2'b01, fetchAddr, memDataIn, 1'b0};
            gotCmd = {memCntrl, memAddr, memDataIn, memIsIndirect};
            nChecks++;
            if (!ok || gotCmd !== expCmd) begin
                nFail++; $display("FAIL rand_cmd[%0d]: ok=%0b got %h required %h", k, ok, gotCmd, expCmd);
            end
            d = $urandom_range(0, 9); rd = 8'($urandom);
            t = 0; got = 1'b0;
            while (!got && t < 12) begin
                t++;
                memDataReady = (t == d + 1);
                memDataOut = rd;
                tick();
                if (fetchAck || dataAck) got = 1'b1;
            end
            memDataReady = 1'b0;
            tout = (d > 6);
            expT = tout ? 7 : d + 1;
            nChecks++;
            if (!got || t != expT || fetchAck !== !expD || dataAck !== expD) begin
                nFail++; $display("FAIL rand_ack[%0d]: cycles=%0d fa=%b da=%b required %0d/%b/%b", k, t, fetchAck, dataAck, expT, !expD, expD);
            end
            mLastData = expD;
            if (tout) mErr = 1'b1;
            else if (!(expD && dataWe)) begin
                if (expD) mDataRData = rd; else mFetchData = rd;
            end
            nChecks++;
            if (fetchData !== mFetchData || dataRData !== mDataRData || timeoutErr !== mErr) begin
                nFail++; $display("FAIL rand_state[%0d]: fd=%h dd=%h err=%b required %h/%h/%b",
                                  k, fetchData, dataRData, timeoutErr, mFetchData, mDataRData, mErr);
            end
            if (expD) dataReq = 1'b0; else fetchReq = 1'b0;
        end
        fetchReq = 1'b0; dataReq = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_store();
        test_timeout();
        test_ready_at_terminal();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #500000;
        nFail++;
        $display("FAIL sim_time_limit: reached 500000 time units, required completion earlier");
        $fatal(1, "simulation time limit reached");
    end

endmodule

`default_nettype wire
